// File: rtl/mips_mem_pkg.sv
// Shared encodings and helpers for the MIPS sub-word data memory.
package mips_mem_pkg;

    // Access size encodings on the request size field.
    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Right-aligned byte-enable pattern for an access size, before shifting by the lane offset.
    function automatic logic [7:0] byte_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            SZ_BYTE: m = 8'h01;
            SZ_HALF: m = 8'h03;
            SZ_WORD: m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mips_load_align.sv
// Load alignment: selects the addressed lanes of a memory word and sign/zero extends them.
module mips_load_align
    import mips_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OFF_WIDTH  = 2
) (
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic [OFF_WIDTH-1:0]  offset_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] keep;
    logic                  sign;

    // Shift the addressed lane to bit 0, keep the access width, fill the rest with the sign.
    always_comb begin
        shifted = word_i >> {offset_i, 3'b000};
        keep    = '1;
        sign    = shifted[DATA_WIDTH-1];
        case (size_i)
            SZ_BYTE: begin
                keep = DATA_WIDTH'(8'hFF);
                sign = shifted[7];
            end
            SZ_HALF: begin
                keep = DATA_WIDTH'(16'hFFFF);
                sign = shifted[15];
            end
            SZ_WORD: begin
                keep = DATA_WIDTH'(32'hFFFF_FFFF);
                sign = shifted[31];
            end
            default: begin
                keep = '1;
                sign = shifted[DATA_WIDTH-1];
            end
        endcase
        data_o = shifted & keep;
        if (!unsigned_i && sign) begin
            data_o = data_o | ~keep;
        end
    end

endmodule

// File: rtl/mips_subword_data_memory.sv
// Sub-word data memory: valid/ready requests, registered 1-cycle response, post-reset clear sweep.
module mips_subword_data_memory
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_err_o,
    output logic                  init_done_o
);

    localparam int unsigned LANES = DATA_WIDTH / 8;
    localparam int unsigned OFFW  = $clog2(LANES);
    localparam int unsigned PTRW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e                state_q, state_d;
    logic [PTRW-1:0]       ptr_q, ptr_d;
    logic                  sweep_we;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  accept;
    logic                  in_range;
    logic                  misaligned;
    logic                  size_bad;
    logic                  req_err;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] idx_full;
    logic [PTRW-1:0]       idx;
    logic [OFFW-1:0]       offset;
    logic [15:0]           be_full;
    logic [LANES-1:0]      be;
    logic [DATA_WIDTH-1:0] wdata_sh;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] ld_data;

    assign req_ready_o = (state_q == ST_READY);
    assign init_done_o = (state_q == ST_READY);
    assign accept      = req_valid_i && req_ready_o;

    // Request decode: word index, lane offset, error checks, store lane mask and data.
    always_comb begin
        idx_full = req_addr_i >> OFFW;
        offset   = req_addr_i[OFFW-1:0];
        in_range = (idx_full < ADDR_WIDTH'(DEPTH));
        // Out-of-range requests read word 0 so the array index never leaves its bounds.
        idx      = in_range ? idx_full[PTRW-1:0] : '0;
        case (req_size_i)
            SZ_HALF:  misaligned = req_addr_i[0];
            SZ_WORD:  misaligned = |req_addr_i[1:0];
            SZ_DWORD: misaligned = |req_addr_i[2:0];
            default:  misaligned = 1'b0;
        endcase
        size_bad = (req_size_i == SZ_DWORD) && (DATA_WIDTH != 64);
        req_err  = misaligned || size_bad || !in_range;
        be_full  = {8'h00, byte_mask(req_size_i)} << offset;
        be       = be_full[LANES-1:0];
        wdata_sh = req_wdata_i << {offset, 3'b000};
        wr_en    = accept && req_we_i && !req_err;
    end

    assign rd_word = mem_q[idx];

    mips_load_align #(
        .DATA_WIDTH(DATA_WIDTH),
        .OFF_WIDTH (OFFW)
    ) u_load_align (
        .word_i    (rd_word),
        .offset_i  (offset),
        .size_i    (req_size_i),
        .unsigned_i(req_unsigned_i),
        .data_o    (ld_data)
    );

    // Clear-sweep FSM: walk every word once after reset, then serve requests forever.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        sweep_we = 1'b0;
        case (state_q)
            ST_INIT: begin
                sweep_we = 1'b1;
                ptr_d    = ptr_q + PTRW'(1);
                if (ptr_q == PTRW'(DEPTH - 1)) begin
                    state_d = ST_READY;
                    ptr_d   = '0;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // FSM state and sweep pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Array write: sweep clears a whole word, stores update only their enabled lanes.
    always_ff @(posedge clk_i) begin
        if (sweep_we) begin
            mem_q[ptr_q] <= '0;
        end else if (wr_en) begin
            for (int l = 0; l < LANES; l++) begin
                if (be[l]) begin
                    mem_q[idx][8*l +: 8] <= wdata_sh[8*l +: 8];
                end
            end
        end
    end

    // Response next-state: pulse valid on accept, hold data/err otherwise.
    always_comb begin
        rsp_valid_d = accept;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        if (accept) begin
            rsp_err_d  = req_err;
            rsp_data_d = (req_we_i || req_err) ? '0 : ld_data;
        end
    end

    // Response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_mips_subword_data_memory.sv
// Scoreboard bench for the sub-word data memory: 32-bit and 64-bit instances, directed vectors.
module tb_mips_subword_data_memory;

    logic clk;
    logic rst_n;

    logic        v32, we32, uns32;
    logic [1:0]  sz32;
    logic [31:0] a32, wd32;
    logic        rdy32, rv32, rerr32, done32;
    logic [31:0] rd32;

    logic        v64, we64, uns64;
    logic [1:0]  sz64;
    logic [31:0] a64;
    logic [63:0] wd64;
    logic        rdy64, rv64, rerr64, done64;
    logic [63:0] rd64;

    int checks = 0;
    int errors = 0;

    logic [63:0] q32_d[$];
    bit          q32_e[$];
    string       q32_n[$];
    logic [63:0] q64_d[$];
    bit          q64_e[$];
    string       q64_n[$];

    mips_subword_data_memory #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .DEPTH     (64)
    ) u_dut32 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (v32),
        .req_ready_o   (rdy32),
        .req_we_i      (we32),
        .req_size_i    (sz32),
        .req_unsigned_i(uns32),
        .req_addr_i    (a32),
        .req_wdata_i   (wd32),
        .rsp_valid_o   (rv32),
        .rsp_data_o    (rd32),
        .rsp_err_o     (rerr32),
        .init_done_o   (done32)
    );

    mips_subword_data_memory #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(64),
        .DEPTH     (64)
    ) u_dut64 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (v64),
        .req_ready_o   (rdy64),
        .req_we_i      (we64),
        .req_size_i    (sz64),
        .req_unsigned_i(uns64),
        .req_addr_i    (a64),
        .req_wdata_i   (wd64),
        .rsp_valid_o   (rv64),
        .rsp_data_o    (rd64),
        .rsp_err_o     (rerr64),
        .init_done_o   (done64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Monitors: pop and compare whenever a DUT presents a response.
    always @(negedge clk) begin : mon32
        logic [63:0] ed;
        bit          ee;
        string       nm;
        if (rv32 === 1'b1) begin
            checks++;
            if (q32_d.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp32: got data=%h err=%b, expected no response", rd32, rerr32);
            end else begin
                ed = q32_d.pop_front();
                ee = q32_e.pop_front();
                nm = q32_n.pop_front();
                if (rd32 !== ed[31:0] || rerr32 !== ee) begin
                    errors++;
                    $display("FAIL %s: got data=%h err=%b, expected data=%h err=%b",
                             nm, rd32, rerr32, ed[31:0], ee);
                end
            end
        end
    end

    always @(negedge clk) begin : mon64
        logic [63:0] ed;
        bit          ee;
        string       nm;
        if (rv64 === 1'b1) begin
            checks++;
            if (q64_d.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp64: got data=%h err=%b, expected no response", rd64, rerr64);
            end else begin
                ed = q64_d.pop_front();
                ee = q64_e.pop_front();
                nm = q64_n.pop_front();
                if (rd64 !== ed || rerr64 !== ee) begin
                    errors++;
                    $display("FAIL %s: got data=%h err=%b, expected data=%h err=%b",
                             nm, rd64, rerr64, ed, ee);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Drive one request for one cycle; caller is at posedge+1, returns at next posedge+1.
    task automatic issue(input bit d64, input bit we, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] ed,
                         input bit ee, input string nm, input bit push);
        if (d64) begin
            v64 = 1'b1; we64 = we; sz64 = sz; uns64 = uns; a64 = addr; wd64 = wd;
            if (push) begin
                q64_d.push_back(ed); q64_e.push_back(ee); q64_n.push_back(nm);
            end
        end else begin
            v32 = 1'b1; we32 = we; sz32 = sz; uns32 = uns; a32 = addr; wd32 = wd[31:0];
            if (push) begin
                q32_d.push_back(ed); q32_e.push_back(ee); q32_n.push_back(nm);
            end
        end
        @(posedge clk);
        #1;
        v32 = 1'b0;
        v64 = 1'b0;
    endtask

    task automatic ld32(input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                        input logic [31:0] ed, input bit ee, input string nm);
        issue(1'b0, 1'b0, sz, uns, addr, 64'(ed), 64'(ed), ee, nm, 1'b1);
    endtask

    task automatic st32(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd,
                        input bit ee, input string nm);
        issue(1'b0, 1'b1, sz, 1'b0, addr, 64'(wd), 64'h0, ee, nm, 1'b1);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (rdy32 !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        v32 = 0; we32 = 0; sz32 = 0; uns32 = 0; a32 = 0; wd32 = 0;
        v64 = 0; we64 = 0; sz64 = 0; uns64 = 0; a64 = 0; wd64 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(rdy32), 64'h0);
        chk("rst_rsp_valid", 64'(rv32), 64'h0);
        chk("rst_rsp_data", 64'(rd32), 64'h0);
        chk("rst_rsp_err", 64'(rerr32), 64'h0);
        chk("rst_init_done", 64'(done32), 64'h0);

        // 1: sweep length and cleared contents
        rst_n = 1'b1;
        wait_ready(n);
        chk("sweep_cycles", 64'(n), 64'd64);
        chk("init_done", 64'(done32), 64'h1);
        chk("ready64", 64'(rdy64), 64'h1);
        ld32(2'b10, 1'b0, 32'h00, 32'h0, 1'b0, "clr_lw0");
        ld32(2'b10, 1'b0, 32'hFC, 32'h0, 1'b0, "clr_lw63");
        ld32(2'b10, 1'b0, 32'h40, 32'h0, 1'b0, "clr_lw16");

        // 2: word store, sub-word loads
        st32(2'b10, 32'h10, 32'h11223344, 1'b0, "sw_10");
        ld32(2'b00, 1'b0, 32'h13, 32'h00000011, 1'b0, "lb_13");
        ld32(2'b00, 1'b1, 32'h10, 32'h00000044, 1'b0, "lbu_10");
        ld32(2'b01, 1'b0, 32'h12, 32'h00001122, 1'b0, "lh_12");
        ld32(2'b01, 1'b0, 32'h10, 32'h00003344, 1'b0, "lh_10");
        ld32(2'b10, 1'b0, 32'h10, 32'h11223344, 1'b0, "lw_10");

        // 3: byte and half stores into a cleared word
        st32(2'b00, 32'h21, 32'hAAAAAA80, 1'b0, "sb_21");
        ld32(2'b00, 1'b0, 32'h21, 32'hFFFFFF80, 1'b0, "lb_21");
        ld32(2'b00, 1'b1, 32'h21, 32'h00000080, 1'b0, "lbu_21");
        ld32(2'b10, 1'b0, 32'h20, 32'h00008000, 1'b0, "lw_20a");
        st32(2'b01, 32'h22, 32'hFFFF9ABC, 1'b0, "sh_22");
        ld32(2'b01, 1'b0, 32'h22, 32'hFFFF9ABC, 1'b0, "lh_22");
        ld32(2'b01, 1'b1, 32'h22, 32'h00009ABC, 1'b0, "lhu_22");
        ld32(2'b10, 1'b0, 32'h20, 32'h9ABC8000, 1'b0, "lw_20b");

        // 4: error cases leave memory untouched
        st32(2'b10, 32'h04, 32'h55667788, 1'b0, "sw_04");
        st32(2'b01, 32'h05, 32'h00001111, 1'b1, "sh_05_misal");
        ld32(2'b10, 1'b0, 32'h04, 32'h55667788, 1'b0, "lw_04");
        ld32(2'b10, 1'b0, 32'h100, 32'h0, 1'b1, "lw_100_range");
        ld32(2'b10, 1'b0, 32'h06, 32'h0, 1'b1, "lw_06_misal");
        ld32(2'b11, 1'b0, 32'h08, 32'h0, 1'b1, "ld_dw32_size");
        st32(2'b00, 32'h100, 32'h000000A5, 1'b1, "sb_100_range");
        ld32(2'b10, 1'b0, 32'h00, 32'h0, 1'b0, "lw_00_nowrap");

        // 5: back-to-back store then load, then hold behaviour
        st32(2'b10, 32'h08, 32'hDEADBEEF, 1'b0, "sw_08");
        ld32(2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 1'b0, "lw_08_b2b");
        @(posedge clk);
        #1;
        chk("idle_valid", 64'(rv32), 64'h0);
        chk("idle_hold_data", 64'(rd32), 64'hDEADBEEF);
        st32(2'b10, 32'hFC, 32'hCAFEF00D, 1'b0, "sw_fc");
        ld32(2'b10, 1'b0, 32'hFC, 32'hCAFEF00D, 1'b0, "lw_fc");

        // 6: reset with a load in flight, then reset mid-sweep
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 64'h0, 64'h0, 1'b0, "inflight", 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_drop_valid", 64'(rv32), 64'h0);
        chk("rst_drop_ready", 64'(rdy32), 64'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("mid_sweep_ready", 64'(rdy32), 64'h0);
        rst_n = 1'b0;
        #1;
        chk("mid_sweep_done", 64'(done32), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ready(n);
        chk("resweep_cycles", 64'(n), 64'd64);
        ld32(2'b10, 1'b0, 32'hFC, 32'h0, 1'b0, "resweep_lw_fc");
        ld32(2'b10, 1'b0, 32'h10, 32'h0, 1'b0, "resweep_lw_10");

        // 64-bit variant
        issue(1'b1, 1'b1, 2'b11, 1'b0, 32'h18, 64'h0123456789ABCDEF, 64'h0, 1'b0, "sd_18", 1'b1);
        issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h18, 64'h0, 64'h0123456789ABCDEF, 1'b0, "ld_18", 1'b1);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h1C, 64'h0, 64'h0000000001234567, 1'b0, "lw64_1c", 1'b1);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h18, 64'h0, 64'hFFFFFFFF89ABCDEF, 1'b0, "lw64_18", 1'b1);
        issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h18, 64'h0, 64'hFFFFFFFFFFFFFFEF, 1'b0, "lb64_18", 1'b1);
        issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h1E, 64'h0, 64'h0000000000000123, 1'b0, "lhu64_1e", 1'b1);
        issue(1'b1, 1'b1, 2'b11, 1'b0, 32'h1C, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1, "sd_1c_misal", 1'b1);
        issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h1F, 64'h0, 64'h0000000000000001, 1'b0, "lbu64_1f", 1'b1);
        issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h200, 64'h0, 64'h0, 1'b1, "ld64_range", 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("pending_rsp32", 64'(q32_d.size()), 64'h0);
        chk("pending_rsp64", 64'(q64_d.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
